// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int MD_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MFHI  = 3'b110,
        OP_MFLO  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    function automatic logic [MD_XLEN-1:0] neg_x(
        input logic [MD_XLEN-1:0] v
    );
        return (~v) + MD_XLEN'(1);
    endfunction

    function automatic logic [MD_XLEN-1:0] abs_x(
        input logic [MD_XLEN-1:0] v
    );
        return v[MD_XLEN-1] ? neg_x(v) : v;
    endfunction

    function automatic logic [2*MD_XLEN-1:0] neg_w(
        input logic [2*MD_XLEN-1:0] v
    );
        return (~v) + (2*MD_XLEN)'(1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring
// shift-subtract for divide, on the {acc, opd} register pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] opd_i,
    input  logic [XLEN-1:0] mcand_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] opd_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shf;
    logic [XLEN:0] dif;

    always_comb begin
        sum = {1'b0, acc_i} + {1'b0, mcand_i};
        shf = {acc_i, opd_i[XLEN-1]};
        dif = shf - {1'b0, mcand_i};
        acc_o = acc_i;
        opd_o = opd_i;
        if (div_i) begin
            // Top bit of dif is the borrow: set means restore.
            if (dif[XLEN]) begin
                acc_o = shf[XLEN-1:0];
                opd_o = {opd_i[XLEN-2:0], 1'b0};
            end else begin
                acc_o = dif[XLEN-1:0];
                opd_o = {opd_i[XLEN-2:0], 1'b1};
            end
        end else if (opd_i[0]) begin
            acc_o = sum[XLEN:1];
            opd_o = {sum[0], opd_i[XLEN-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[XLEN-1:1]};
            opd_o = {acc_i[0], opd_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO owner: sequences 32-step multiply/divide, handles MT*/MF*,
// and stalls requests that arrive while an operation is in flight.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs,
    input  logic [XLEN-1:0] rt,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] rd_data,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] opd_q, opd_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] rsv_q, rsv_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            div_q, div_d;
    logic            sgnq_q, sgnq_d;
    logic            sgnr_q, sgnr_d;
    logic            dz_q, dz_d;
    logic            done_q, done_d;

    logic [XLEN-1:0]   acc_n;
    logic [XLEN-1:0]   opd_n;
    logic [2*XLEN-1:0] prod;
    logic              is_sgn;
    op_t               op_e;

    assign op_e   = op_t'(op);
    assign is_sgn = ~op[0];

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .opd_i  (opd_q),
        .mcand_i(mcand_q),
        .acc_o  (acc_n),
        .opd_o  (opd_n)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opd_d   = opd_q;
        mcand_d = mcand_q;
        rsv_d   = rsv_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div_d   = div_q;
        sgnq_d  = sgnq_q;
        sgnr_d  = sgnr_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        prod    = sgnq_q ? neg_w({acc_q, opd_q}) : {acc_q, opd_q};

        unique case (state_q)
            IDLE: begin
                if (req && !flush) begin
                    unique case (op_e)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            state_d = RUN;
                            cnt_d   = CW'(XLEN - 1);
                            div_d   = op[1];
                            acc_d   = '0;
                            opd_d   = is_sgn ? abs_x(rs) : rs;
                            mcand_d = is_sgn ? abs_x(rt) : rt;
                            sgnq_d  = is_sgn & (rs[XLEN-1] ^ rt[XLEN-1]);
                            sgnr_d  = is_sgn & rs[XLEN-1];
                            dz_d    = op[1] && (rt == '0);
                            rsv_d   = rs;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_n;
                    opd_d = opd_n;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (!div_q) begin
                        {hi_d, lo_d} = prod;
                    end else if (dz_q) begin
                        hi_d = rsv_q;
                        lo_d = '1;
                    end else begin
                        lo_d = sgnq_q ? neg_x(opd_q) : opd_q;
                        hi_d = sgnr_q ? neg_x(acc_q) : acc_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opd_q   <= '0;
            mcand_q <= '0;
            rsv_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            sgnq_q  <= 1'b0;
            sgnr_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opd_q   <= opd_d;
            mcand_q <= mcand_d;
            rsv_q   <= rsv_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div_q   <= div_d;
            sgnq_q  <= sgnq_d;
            sgnr_q  <= sgnr_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign stall   = req && busy && !flush;
    assign done    = done_q;
    assign rd_data = (op_e == OP_MFHI) ? hi_q : lo_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle MIPS multiply/divide unit that owns the HI/LO architectural registers.
- Accepts MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO from the execute stage.
- Runs multiplies and divides iteratively, one bit per cycle, and stalls the pipeline when a HI/LO access collides with an operation in flight.
- Replaces the single-cycle combinational HI/LO datapath.

Parameters:
XLEN, 32, operand width; HI/LO are XLEN each; iteration count = XLEN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  1  valid HI/LO-unit instruction this cycle
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
rs  in  XLEN  operand 1 (dividend / multiplicand / MT source)
rt  in  XLEN  operand 2 (divisor / multiplier)
flush  in  1  pipeline flush; cancels any in-flight op
stall  out  1  combinational: req && busy && !flush
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after HI/LO written by MULT/DIV
rd_data  out  XLEN  combinational: hi when op==MFHI, else lo
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset: asynchronous, active low. State=IDLE; hi, lo, done, counter and internal accumulators all 0. Reset mid-operation aborts the operation with no HI/LO write.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on req && !flush && op∈{MULT,MULTU,DIV,DIVU}.
  - RUN -> FIX after XLEN iterations (counter XLEN-1 down to 0).
  - FIX -> IDLE always.
  - flush in RUN or FIX -> IDLE next edge; no write; no done.
- Accept, edge 0: latch operand magnitudes. For signed ops, record sign_q = rs[XLEN-1]^rt[XLEN-1] and sign_r = rs[XLEN-1]. Unsigned ops take operands as-is.
- RUN, edges 1..XLEN: one radix-2 shift-add (MUL) or restoring shift-subtract (DIV) step per edge.
- FIX, edge XLEN+1: sign correction, then write hi/lo.
  - MULT: negate the 2·XLEN product if sign_q.
  - DIV: negate the quotient if sign_q; negate the remainder if sign_r.
  - done=1 during the following cycle only.
  - Total latency: accept to HI/LO visible is XLEN+1 edges (33 for XLEN=32).
- Divide by zero (rt==0), DIV and DIVU: lo = all ones, hi = rs unchanged. This is a forced override in FIX and bypasses sign correction.
- Signed overflow (0x80000000 / -1): lo=0x80000000, hi=0. This falls out of the magnitude method; no special case.
- MTHI/MTLO in IDLE: hi (resp. lo) <= rs at next edge; single cycle; busy stays 0.
- MFHI/MFLO in IDLE: rd_data valid same cycle; no state change.
- Any req while busy: stall=1, op not accepted. Requester holds req/op/rs/rt stable until stall=0.
  - In the done cycle busy=0, so a held MF request completes that cycle and reads the new value.
- flush with req in the same cycle: flush wins; req ignored; stall=0. flush in IDLE: no effect.
- op values outside a valid req are ignored; HI/LO change only via MT* or FIX.

Decomposition:
- Package muldiv_pkg holds:
  - op_t enum (8 encodings above)
  - state_t enum {IDLE, RUN, FIX}
  - XLEN default
  - negate/abs helper functions
- Sub-module muldiv_step: combinational single-iteration datapath. Inputs are mode and {acc, operand}; output is the next {acc, operand}. Sequencer keeps state, counter, sign flags and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy for 33 cycles; hi=0xFFFFFFFE, lo=0x00000001 after edge 33; done pulses one cycle.
- MULT rs=0xFFFFFFFD (-3) rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIVU 7/2 -> lo=3, hi=1.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x12345678 rt=0 -> lo=0xFFFFFFFF, hi=0x12345678.
- DIVU 100/7 followed 5 cycles later by held MFLO -> stall=1 until done cycle; rd_data=14 that cycle. Then MTHI rs=0xA -> hi=0xA next edge, busy never asserted.
- Preload hi=0xA, lo=0xB; MULT 3*4, flush at RUN cycle 10 -> busy=0 next cycle; hi/lo stay 0xA/0xB; no done. Repeat with rst_n low mid-RUN -> hi=lo=0 immediately; state IDLE.
